// File: rtl/hilo_muldiv_unit_if.sv
// Handshake bundle between the pipeline and the HiLo mul/div engine.
// master: issues Start/Op/operands; slave: returns Busy and the result strobe.
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic               Start;
  logic [2:0]         Op;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] HiLoIn;
  logic               Busy;
  logic               WriteEnable;
  logic [2*WIDTH-1:0] WriteData;
  logic               DivByZero;

  modport master (
    output Start, Op, A, B, HiLoIn,
    input  Busy, WriteEnable, WriteData, DivByZero
  );

  modport slave (
    input  Start, Op, A, B, HiLoIn,
    output Busy, WriteEnable, WriteData, DivByZero
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MADD/MSUB engine feeding the HiLo register.
// Ports: Clk, Reset (async active-low), bus (slave: Start/Op/A/B/HiLoIn in; Busy/WriteEnable/WriteData/DivByZero out).
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input logic              Clk,
  input logic              Reset,
  hilo_muldiv_unit_if.slave bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        op_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_mag;
  logic [W2-1:0]     hilo_q;
  logic [W2-1:0]     p_q;
  logic              neg_q;
  logic              neg_rem_q;
  logic              b_zero_q;
  logic [CW-1:0]     count;
  logic              we_q;
  logic              dbz_q;
  logic [W2-1:0]     wdata_q;

  logic              op_ok;
  logic              op_signed;
  logic              launch;
  logic              is_div;
  logic [WIDTH-1:0]  a_mag_in;
  logic [WIDTH-1:0]  b_mag_in;
  logic [WIDTH:0]    mul_hi;
  logic [W2-1:0]     mul_nxt;
  logic [WIDTH:0]    rem_sh;
  logic [WIDTH:0]    diff;
  logic [W2-1:0]     div_nxt;
  logic [W2-1:0]     prod_s;
  logic [WIDTH-1:0]  quo;
  logic [WIDTH-1:0]  rem;
  logic [W2-1:0]     result;

  assign op_ok     = bus.Op <= 3'b101;
  assign launch    = (state == IDLE) && bus.Start && op_ok;
  // MULT, DIV, MADD, MSUB are signed; MULTU/DIVU are not
  assign op_signed = !bus.Op[0] || bus.Op[2];
  assign is_div    = op_q[2:1] == 2'b01;

  assign a_mag_in = (op_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign b_mag_in = (op_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

  // Shift-add: multiplier sits in the low half, product grows from the top
  assign mul_hi  = p_q[0] ? {1'b0, p_q[W2-1:WIDTH]} + {1'b0, b_mag}
                          : {1'b0, p_q[W2-1:WIDTH]};
  assign mul_nxt = {mul_hi, p_q[WIDTH-1:1]};

  // Restoring divide: {rem, dividend/quotient} shifts left one bit per step
  assign rem_sh  = {p_q[W2-1:WIDTH], p_q[WIDTH-1]};
  assign diff    = rem_sh - {1'b0, b_mag};
  assign div_nxt = diff[WIDTH]
                 ? {rem_sh[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0}
                 : {diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};

  assign prod_s = neg_q ? -p_q : p_q;
  assign quo    = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
  assign rem    = neg_rem_q ? -p_q[W2-1:WIDTH] : p_q[W2-1:WIDTH];

  always_comb begin
    result = prod_s;
    unique case (1'b1)
      is_div && b_zero_q:  result = {a_q, {WIDTH{1'b1}}};
      is_div && !b_zero_q: result = {rem, quo};
      op_q == 3'b100:      result = hilo_q + prod_s;
      op_q == 3'b101:      result = hilo_q - prod_s;
      default:             result = prod_s;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (launch) state_nxt = RUN;
      RUN:     if (count == CW'(ITER - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      op_q      <= '0;
      a_q       <= '0;
      b_mag     <= '0;
      hilo_q    <= '0;
      p_q       <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      count     <= '0;
      we_q      <= 1'b0;
      dbz_q     <= 1'b0;
      wdata_q   <= '0;
    end else begin
      if (launch) begin
        op_q      <= bus.Op;
        a_q       <= bus.A;
        b_mag     <= b_mag_in;
        hilo_q    <= bus.HiLoIn;
        p_q       <= {{WIDTH{1'b0}}, a_mag_in};
        neg_q     <= op_signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
        neg_rem_q <= op_signed && bus.A[WIDTH-1];
        b_zero_q  <= bus.B == '0;
        count     <= '0;
      end else if (state == RUN) begin
        p_q   <= is_div ? div_nxt : mul_nxt;
        count <= count + 1'b1;
      end
      we_q  <= state == FIX;
      dbz_q <= (state == FIX) && is_div && b_zero_q;
      if (state == FIX) wdata_q <= result;
    end
  end

  assign bus.Busy        = state != IDLE;
  assign bus.WriteEnable = we_q;
  assign bus.WriteData   = wdata_q;
  assign bus.DivByZero   = dbz_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit.
// Drives stimulus on the falling edge, samples 1ns after the rising edge.
module tb_hilo_muldiv_unit;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  hilo_muldiv_unit_if bus();

  hilo_muldiv_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic launch(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] hl);
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op = op;
    bus.A = a;
    bus.B = b;
    bus.HiLoIn = hl;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
  endtask

  // Latency counted in rising edges from the call; 0 means no strobe seen.
  task automatic wait_we(output int lat, output int busy_cnt,
                         output logic [63:0] data, output logic dbz);
    lat = 0;
    busy_cnt = bus.Busy ? 1 : 0;
    data = '0;
    dbz = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clk);
      #1;
      if (bus.WriteEnable) begin
        lat = i;
        data = bus.WriteData;
        dbz = bus.DivByZero;
        break;
      end
      if (bus.Busy) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    #12;
    n_checks++;
    if (bus.Busy !== 1'b0 || bus.WriteEnable !== 1'b0 ||
        bus.DivByZero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b we=%b dbz=%b required 0 0 0",
               bus.Busy, bus.WriteEnable, bus.DivByZero);
    end
    n_checks++;
    if (bus.WriteData !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", bus.WriteData);
    end
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_mult;
    int lat, bc;
    logic [63:0] d;
    logic z;
    launch(3'b000, 32'hFFFFFFFD, 32'd7, 64'h0);
    wait_we(lat, bc, d, z);
    n_checks++;
    if (lat !== 33) begin
      n_fail++;
      $display("FAIL mult_latency: got %0d required 33", lat);
    end
    n_checks++;
    if (d !== 64'hFFFFFFFF_FFFFFFEB) begin
      n_fail++;
      $display("FAIL mult_data: got %h required ffffffffffffffeb", d);
    end
    n_checks++;
    if (bc !== 33) begin
      n_fail++;
      $display("FAIL mult_busy_cycles: got %0d required 33", bc);
    end
    @(posedge Clk);
    #1;
    n_checks++;
    if (bus.WriteEnable !== 1'b0 || bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mult_single_strobe: we=%b busy=%b required 0 0",
               bus.WriteEnable, bus.Busy);
    end
    n_checks++;
    if (bus.WriteData !== 64'hFFFFFFFF_FFFFFFEB) begin
      n_fail++;
      $display("FAIL mult_hold: got %h required ffffffffffffffeb",
               bus.WriteData);
    end
  endtask

  task automatic test_multu_madd_msub;
    int lat, bc;
    logic [63:0] d;
    logic z;
    launch(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0);
    wait_we(lat, bc, d, z);
    n_checks++;
    if (d !== 64'hFFFFFFFE_00000001 || lat !== 33) begin
      n_fail++;
      $display("FAIL multu: got %h lat %0d required fffffffe00000001 lat 33",
               d, lat);
    end
    launch(3'b100, 32'd3, 32'd4, 64'd10);
    wait_we(lat, bc, d, z);
    n_checks++;
    if (d !== 64'd22 || lat !== 33) begin
      n_fail++;
      $display("FAIL madd: got %h lat %0d required 16 lat 33", d, lat);
    end
    launch(3'b101, 32'd1, 32'd1, 64'd0);
    wait_we(lat, bc, d, z);
    n_checks++;
    if (d !== 64'hFFFFFFFF_FFFFFFFF || lat !== 33) begin
      n_fail++;
      $display("FAIL msub: got %h lat %0d required ffffffffffffffff lat 33",
               d, lat);
    end
    launch(3'b101, 32'hFFFFFFFE, 32'd5, 64'd100);
    wait_we(lat, bc, d, z);
    n_checks++;
    if (d !== 64'd110) begin
      n_fail++;
      $display("FAIL msub_neg: got %h required 6e", d);
    end
  endtask

  task automatic test_div;
    int lat, bc;
    logic [63:0] d;
    logic z;
    launch(3'b010, 32'hFFFFFFF9, 32'd2, 64'h0);
    wait_we(lat, bc, d, z);
    n_checks++;
    if (d !== {32'hFFFFFFFF, 32'hFFFFFFFD} || z !== 1'b0) begin
      n_fail++;
      $display("FAIL div_signed: got %h dbz %b required fffffffffffffffd 0",
               d, z);
    end
    launch(3'b011, 32'd100, 32'd7, 64'h0);
    wait_we(lat, bc, d, z);
    n_checks++;
    if (d !== {32'd2, 32'd14} || lat !== 33) begin
      n_fail++;
      $display("FAIL divu: got %h lat %0d required 000000020000000e lat 33",
               d, lat);
    end
    launch(3'b010, 32'h80000000, 32'hFFFFFFFF, 64'h0);
    wait_we(lat, bc, d, z);
    n_checks++;
    if (d !== {32'h0, 32'h80000000} || z !== 1'b0) begin
      n_fail++;
      $display("FAIL div_overflow: got %h dbz %b required 0000000080000000 0",
               d, z);
    end
  endtask

  task automatic test_div_zero;
    int lat, bc;
    logic [63:0] d;
    logic z;
    launch(3'b011, 32'h64, 32'h0, 64'h0);
    wait_we(lat, bc, d, z);
    n_checks++;
    if (d !== {32'h64, 32'hFFFFFFFF} || lat !== 33) begin
      n_fail++;
      $display("FAIL divzero_data: got %h lat %0d required 00000064ffffffff 33",
               d, lat);
    end
    n_checks++;
    if (z !== 1'b1) begin
      n_fail++;
      $display("FAIL divzero_flag: got %b required 1", z);
    end
    @(posedge Clk);
    #1;
    n_checks++;
    if (bus.DivByZero !== 1'b0) begin
      n_fail++;
      $display("FAIL divzero_pulse: got %b required 0", bus.DivByZero);
    end
  endtask

  task automatic test_start_ignored;
    int lat, bc;
    logic [63:0] d;
    logic z;
    launch(3'b001, 32'd3, 32'd4, 64'h0);
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op = 3'b011;
    bus.A = 32'd100;
    bus.B = 32'd7;
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    wait_we(lat, bc, d, z);
    n_checks++;
    if (d !== 64'd12 || lat !== 23) begin
      n_fail++;
      $display("FAIL start_midrun: got %h lat %0d required c lat 23", d, lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    logic [63:0] d;
    logic z;
    launch(3'b001, 32'd2, 32'd3, 64'h0);
    wait_we(lat, bc, d, z);
    n_checks++;
    if (d !== 64'd6) begin
      n_fail++;
      $display("FAIL b2b_first: got %h required 6", d);
    end
    launch(3'b001, 32'd7, 32'd8, 64'h0);
    wait_we(lat, bc, d, z);
    n_checks++;
    if (d !== 64'd56 || lat !== 33) begin
      n_fail++;
      $display("FAIL b2b_second: got %h lat %0d required 38 lat 33", d, lat);
    end
  endtask

  task automatic test_reserved;
    int strobes;
    launch(3'b110, 32'd5, 32'd5, 64'h0);
    n_checks++;
    if (bus.Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reserved_busy: got %b required 0", bus.Busy);
    end
    strobes = 0;
    repeat (40) begin
      @(posedge Clk);
      #1;
      if (bus.WriteEnable || bus.Busy) strobes++;
    end
    n_checks++;
    if (strobes !== 0) begin
      n_fail++;
      $display("FAIL reserved_activity: got %0d cycles required 0", strobes);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bc, strobes;
    logic [63:0] d;
    logic z;
    launch(3'b000, 32'd9, 32'd9, 64'h0);
    repeat (15) @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    n_checks++;
    if (bus.Busy !== 1'b0 || bus.WriteEnable !== 1'b0 ||
        bus.WriteData !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_async: busy=%b we=%b data=%h required 0 0 0",
               bus.Busy, bus.WriteEnable, bus.WriteData);
    end
    @(negedge Clk);
    Reset = 1'b1;
    strobes = 0;
    repeat (40) begin
      @(posedge Clk);
      #1;
      if (bus.WriteEnable) strobes++;
    end
    n_checks++;
    if (strobes !== 0) begin
      n_fail++;
      $display("FAIL reset_no_strobe: got %0d strobes required 0", strobes);
    end
    launch(3'b000, 32'd5, 32'd6, 64'h0);
    wait_we(lat, bc, d, z);
    n_checks++;
    if (d !== 64'd30 || lat !== 33) begin
      n_fail++;
      $display("FAIL reset_fresh: got %h lat %0d required 1e lat 33", d, lat);
    end
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.Op = 3'b000;
    bus.A = '0;
    bus.B = '0;
    bus.HiLoIn = '0;
    test_reset;
    test_mult;
    test_multu_madd_msub;
    test_div;
    test_div_zero;
    test_start_ignored;
    test_back_to_back;
    test_reserved;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide engine that sits directly upstream of the HiLo register.
- Executes MIPS MULT, MULTU, DIV, DIVU, MADD and MSUB on two 32-bit operands.
- Produces the 64-bit {Hi,Lo} result with a single-cycle write strobe; that strobe drives the HiLo register's WriteEnable/WriteData.
- Busy is provided so the pipeline can stall MFHI/MFLO and further mul/div instructions until the result is written.

Parameters:
- WIDTH, 32, operand width; result width is 2*WIDTH.
- ITER, 32, iterations per operation; must equal WIDTH.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  launch request; sampled only in IDLE.
- Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MSUB; 110/111 reserved.
- A  input  32  rs operand (multiplicand/dividend).
- B  input  32  rt operand (multiplier/divisor).
- HiLoIn  input  64  current HiLo register contents, used by MADD/MSUB.
- Busy  output  1  high while an operation is in flight.
- WriteEnable  output  1  one-cycle result strobe to HiLo register.
- WriteData  output  64  {Hi,Lo} result.
- DivByZero  output  1  pulses with WriteEnable when DIV/DIVU had B==0.

Behaviour:
- Reset low (async): state=IDLE; Busy=0, WriteEnable=0, DivByZero=0, WriteData=0; iteration counter and datapath registers cleared. Any in-flight operation is discarded and no strobe is issued.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - On an edge with Start=1 and Op valid (000-101): latch Op, A, B and HiLoIn; convert operands to magnitudes for signed ops; count=0; go to RUN; Busy=1 from that edge.
  - Start=0 or reserved Op: stay in IDLE, no effect.
- RUN: one iteration per edge; count increments; after the 32nd iteration edge go to FIX.
  - Multiply: shift-add over the unsigned magnitudes into a 64-bit product.
  - Divide: restoring shift-subtract, producing 32-bit quotient and remainder.
- FIX edge (33rd edge after the launch edge):
  - Apply sign correction.
  - Signed multiply: product negated if sign(A)!=sign(B).
  - Signed divide: quotient negated if signs differ; remainder takes the sign of A (truncation toward zero).
  - MADD: WriteData = HiLoIn + signed product. MSUB: WriteData = HiLoIn - signed product. Both are modulo 2^64.
  - Multiply: WriteData = product.
  - Divide: WriteData = {remainder, quotient}.
  - DIV/DIVU with B==0: WriteData = {A, 32'hFFFFFFFF}, DivByZero=1. Full latency is still consumed.
  - DIV of 32'h80000000 by 32'hFFFFFFFF: WriteData = {32'h0, 32'h80000000}, no flag.
  - Registered outputs: WriteEnable=1 (and DivByZero where applicable) for exactly the cycle after the FIX edge; Busy drops to 0 on the same edge; next state is IDLE.
- Latency: launch edge E0 -> WriteEnable visible after E33. Back-to-back: a Start during the strobe cycle is accepted (state is IDLE), so the next strobe follows 33 edges later.
- Start while Busy=1 is ignored; operands and Op changing during RUN have no effect.
- WriteData holds its value after the strobe until the next FIX edge.
- The downstream HiLo register captures on the falling edge; WriteEnable/WriteData are stable for the whole strobe cycle.

Test Plan:
- MULT A=32'hFFFFFFFD (-3), B=7 -> single WriteEnable 33 edges after launch, WriteData=64'hFFFFFFFF_FFFFFFEB, Busy high 33 cycles.
- MULTU A=B=32'hFFFFFFFF -> WriteData=64'hFFFFFFFE_00000001; then MADD HiLoIn=64'd10, A=3, B=4 -> 64'd22; MSUB HiLoIn=0, A=1, B=1 -> 64'hFFFFFFFF_FFFFFFFF.
- DIV A=-7 (32'hFFFFFFF9), B=2 -> WriteData={32'hFFFFFFFF, 32'hFFFFFFFD}; DIVU A=100, B=7 -> {32'd2, 32'd14}; DIV 32'h80000000 / 32'hFFFFFFFF -> {0, 32'h80000000}.
- DIVU A=32'h64, B=0 -> WriteData={32'h00000064, 32'hFFFFFFFF}, DivByZero=1 for one cycle coincident with WriteEnable.
- Start pulsed mid-RUN with different operands -> ignored, first result unchanged. Start in the strobe cycle -> second result 33 edges later. Reserved Op=3'b110 in IDLE -> Busy stays 0.
- Reset driven low asynchronously at iteration 15 -> Busy/WriteEnable drop immediately. No strobe is produced. After release, a fresh MULT 5*6 returns 64'd30.
